color_palette: RTL

Parametrised successor to the original colour RAM. It resolves per-pixel layer priority with transparency across NUM_LAYERS graphic layers and looks the winner up in a single-port palette store. It arbitrates CPU read/write access against pixel fetches with a req/ack handshake and starvation guard, and drives a registered, blank-gated colour word to the monitor interface.

---
 rtl/color_palette_pkg.sv | 47 ++++
 rtl/palette_store.sv | 22 ++
 rtl/color_palette.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/color_palette_pkg.sv
// Shared constants, CPU FSM state type and the layer-priority resolver for color_palette.
package color_palette_pkg;

  localparam int DEF_NUM_LAYERS = 4;
  localparam int DEF_PIX_W      = 8;
  localparam int DEF_COLOR_W    = 16;
  localparam int DEF_STARVE_MAX = 8;

  // Upper bounds for the generic resolver; instances must fit inside them.
  localparam int MAX_LAYERS  = 16;
  localparam int MAX_LAYER_W = 4;
  localparam int MAX_PIX_W   = 16;
  localparam int MAX_ADDR_W  = MAX_LAYER_W + MAX_PIX_W;

  typedef logic [MAX_LAYERS*MAX_PIX_W-1:0] pix_bus_t;

  typedef enum logic {
    IDLE = 1'b0,
    DONE = 1'b1
  } cpu_state_e;

  // Returns {layer_id, index} right-aligned; the caller keeps the low LAYER_W+PIX_W bits.
  function automatic logic [MAX_ADDR_W-1:0] resolve_layer(
    input pix_bus_t                pix_data,
    input logic [MAX_LAYERS-1:0]   layer_en,
    input logic                    force_en,
    input logic [MAX_LAYER_W-1:0]  force_layer,
    input int unsigned             num_layers,
    input int unsigned             pix_w
  );
    logic [MAX_LAYER_W-1:0] id;
    logic [MAX_PIX_W-1:0]   mask;
    logic [MAX_PIX_W-1:0]   idx;
    logic                   en_k;
    id   = '0;
    mask = MAX_PIX_W'((33'd1 << pix_w) - 33'd1);
    for (int unsigned k = 1; k < MAX_LAYERS; k++) begin
      en_k = 1'(layer_en >> k);
      idx  = MAX_PIX_W'(pix_data >> (k * pix_w)) & mask;
      if (k < num_layers && en_k && idx != '0) id = MAX_LAYER_W'(k);
    end
    if (force_en) id = force_layer;
    idx = MAX_PIX_W'(pix_data >> (32'(id) * pix_w)) & mask;
    return (MAX_ADDR_W'(id) << pix_w) | MAX_ADDR_W'(idx);
  endfunction

endpackage

// File: rtl/palette_store.sv
// Single-port synchronous palette RAM; read returns the pre-write contents of the addressed word.
module palette_store
  import color_palette_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int COLOR_W = DEF_COLOR_W
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [COLOR_W-1:0] wdata,
  output logic [COLOR_W-1:0] q
);

  logic [COLOR_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    q <= mem[addr];
  end

endmodule

// File: rtl/color_palette.sv
// Layer priority, CPU/pixel arbitration of the palette port and the blank-gated colour output register.
module color_palette
  import color_palette_pkg::*;
#(
  parameter int  NUM_LAYERS = DEF_NUM_LAYERS,
  parameter int  PIX_W      = DEF_PIX_W,
  parameter int  COLOR_W    = DEF_COLOR_W,
  parameter int  STARVE_MAX = DEF_STARVE_MAX,
  localparam int LAYER_W    = $clog2(NUM_LAYERS),
  localparam int ADDR_W     = LAYER_W + PIX_W
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       pix_en,
  input  logic [NUM_LAYERS*PIX_W-1:0] pix_data,
  input  logic [NUM_LAYERS-1:0]      layer_en,
  input  logic                       force_en,
  input  logic [LAYER_W-1:0]         force_layer,
  input  logic                       blank,
  input  logic                       cpu_req,
  input  logic                       cpu_we,
  input  logic [ADDR_W-1:0]          cpu_addr,
  input  logic [COLOR_W-1:0]         cpu_wdata,
  output logic                       cpu_ack,
  output logic [COLOR_W-1:0]         cpu_rdata,
  output logic [COLOR_W-1:0]         color_out,
  output logic                       color_valid,
  output logic                       pix_drop
);

  localparam int WAIT_W = $clog2(STARVE_MAX + 1);

  pix_bus_t                 pix_ext;
  logic [MAX_LAYERS-1:0]    en_ext;
  logic [MAX_LAYER_W-1:0]   fl_ext;
  logic [MAX_ADDR_W-1:0]    addr_full;
  logic [ADDR_W-1:0]        pix_addr;
  logic                     unused_addr_hi;

  always_comb begin
    pix_ext = '0;
    pix_ext[NUM_LAYERS*PIX_W-1:0] = pix_data;
    en_ext = '0;
    en_ext[NUM_LAYERS-1:0] = layer_en;
    fl_ext = '0;
    fl_ext[LAYER_W-1:0] = force_layer;
  end

  assign addr_full      = resolve_layer(pix_ext, en_ext, force_en, fl_ext,
                                        NUM_LAYERS, PIX_W);
  assign pix_addr       = addr_full[ADDR_W-1:0];
  assign unused_addr_hi = ^addr_full[MAX_ADDR_W-1:ADDR_W];

  cpu_state_e          state_q;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic                cpu_ack_q;
  logic                rd_pend_q;
  logic [COLOR_W-1:0]  rdata_q;

  logic                starved;
  logic                grant;
  logic                steal;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [COLOR_W-1:0]  ram_q;

  assign starved  = wait_cnt_q >= WAIT_W'(STARVE_MAX);
  assign grant    = (state_q == IDLE) && cpu_req && (!pix_en || starved);
  assign steal    = grant && pix_en;
  assign ram_we   = grant && cpu_we;
  assign ram_addr = grant ? cpu_addr : pix_addr;

  palette_store #(
    .ADDR_W  (ADDR_W),
    .COLOR_W (COLOR_W)
  ) u_store (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (cpu_wdata),
    .q     (ram_q)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      cpu_ack_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      rdata_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cpu_ack_q <= 1'b0;
          if (grant) begin
            state_q   <= DONE;
            cpu_ack_q <= 1'b1;
            rd_pend_q <= !cpu_we;
          end else if (cpu_req && pix_en) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q    <= IDLE;
          cpu_ack_q  <= 1'b0;
          wait_cnt_q <= '0;
          if (rd_pend_q) rdata_q <= ram_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read data comes straight off the RAM in the ack cycle, then from the hold register.
  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = (state_q == DONE && rd_pend_q) ? ram_q : rdata_q;

  logic               p1_valid_q;
  logic               p1_steal_q;
  logic               p1_blank_q;
  logic [COLOR_W-1:0] color_out_q;
  logic [COLOR_W-1:0] color_d;
  logic               color_valid_q;
  logic               pix_drop_q;

  // A stolen slot repeats the last colour, but blanking still wins.
  assign color_d = p1_blank_q ? '0 : (p1_steal_q ? color_out_q : ram_q);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      p1_valid_q    <= 1'b0;
      p1_steal_q    <= 1'b0;
      p1_blank_q    <= 1'b0;
      color_out_q   <= '0;
      color_valid_q <= 1'b0;
      pix_drop_q    <= 1'b0;
    end else begin
      p1_valid_q    <= pix_en;
      p1_steal_q    <= steal;
      p1_blank_q    <= blank;
      color_valid_q <= p1_valid_q;
      pix_drop_q    <= p1_valid_q && p1_steal_q;
      if (p1_valid_q) color_out_q <= color_d;
    end
  end

  assign color_out   = color_out_q;
  assign color_valid = color_valid_q;
  assign pix_drop    = pix_drop_q;

endmodule
